// File: rtl/risc_pkg.sv
// Shared constants for the 8-bit RISC CPU: opcodes, sequencer phases, datapath width.
package risc_pkg;

  localparam int unsigned WIDTH = 8;

  typedef logic [2:0] opcode_t;
  typedef logic [2:0] phase_t;

  localparam opcode_t OP_HLT = 3'b000;
  localparam opcode_t OP_SKZ = 3'b001;
  localparam opcode_t OP_ADD = 3'b010;
  localparam opcode_t OP_AND = 3'b011;
  localparam opcode_t OP_XOR = 3'b100;
  localparam opcode_t OP_LDA = 3'b101;
  localparam opcode_t OP_STO = 3'b110;
  localparam opcode_t OP_JMP = 3'b111;

  localparam phase_t PH_INST_ADDR  = 3'd0;
  localparam phase_t PH_INST_FETCH = 3'd1;
  localparam phase_t PH_INST_LOAD  = 3'd2;
  localparam phase_t PH_IDLE       = 3'd3;
  localparam phase_t PH_OP_ADDR    = 3'd4;
  localparam phase_t PH_OP_FETCH   = 3'd5;
  localparam phase_t PH_ALU_OP     = 3'd6;
  localparam phase_t PH_STORE      = 3'd7;

endpackage

// File: rtl/risc_phase_counter.sv
// 3-bit wrapping phase counter; advances on ena unless frozen.
module risc_phase_counter
  import risc_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   ena,
  input  logic   freeze,
  output phase_t phase
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= PH_INST_ADDR;
    end else if (ena && !freeze) begin
      phase <= phase + 3'd1;
    end
  end

endmodule

// File: rtl/risc_controller.sv
// 8-phase instruction sequencer: decodes phase and opcode into bus, load, PC and memory controls.
module risc_controller
  import risc_pkg::*;
#(
  parameter bit HALT_STICKY = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       halt,
  output logic       inc_pc,
  output logic       ld_ac,
  output logic       ld_pc,
  output logic       wr,
  output logic       data_e,
  output logic [2:0] phase
);

  logic halted_q;
  logic hlt_now;
  logic freeze;
  logic alu_op;

  assign hlt_now = (phase == PH_OP_ADDR) && (opcode == OP_HLT);
  // Latch the halt so a later opcode change cannot restart the sequencer.
  assign freeze  = HALT_STICKY && (hlt_now || halted_q);
  assign alu_op  = opcode inside {OP_ADD, OP_AND, OP_XOR, OP_LDA};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted_q <= 1'b0;
    end else if (freeze) begin
      halted_q <= 1'b1;
    end
  end

  risc_phase_counter u_phase_counter (
    .clk    (clk),
    .rst    (rst),
    .ena    (ena),
    .freeze (freeze),
    .phase  (phase)
  );

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    halt   = 1'b0;
    inc_pc = 1'b0;
    ld_ac  = 1'b0;
    ld_pc  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    case (phase)
      PH_INST_ADDR: begin
        sel = 1'b1;
      end
      PH_INST_FETCH: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      PH_INST_LOAD, PH_IDLE: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      PH_OP_ADDR: begin
        halt   = (opcode == OP_HLT) || halted_q;
        inc_pc = 1'b1;
      end
      PH_OP_FETCH: begin
        rd = alu_op;
      end
      PH_ALU_OP: begin
        rd     = alu_op;
        inc_pc = (opcode == OP_SKZ) && zero;
        ld_pc  = (opcode == OP_JMP);
        data_e = (opcode == OP_STO);
      end
      PH_STORE: begin
        rd     = alu_op;
        ld_ac  = alu_op;
        ld_pc  = (opcode == OP_JMP);
        wr     = (opcode == OP_STO);
        data_e = (opcode == OP_STO);
      end
      default: begin
        sel = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_risc_controller.sv
// Scoreboard bench: stimulus pushes model expectations, a monitor pops and compares both halt modes.
module tb_risc_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic [2:0] opcode = 3'b000;
  logic       zero = 1'b0;

  logic       s_sel, s_rd, s_ld_ir, s_halt, s_inc_pc, s_ld_ac, s_ld_pc, s_wr, s_data_e;
  logic [2:0] s_phase;
  logic       n_sel, n_rd, n_ld_ir, n_halt, n_inc_pc, n_ld_ac, n_ld_pc, n_wr, n_data_e;
  logic [2:0] n_phase;

  risc_controller #(.HALT_STICKY(1'b1)) dut (
    .clk(clk), .rst(rst), .ena(ena), .opcode(opcode), .zero(zero),
    .sel(s_sel), .rd(s_rd), .ld_ir(s_ld_ir), .halt(s_halt), .inc_pc(s_inc_pc),
    .ld_ac(s_ld_ac), .ld_pc(s_ld_pc), .wr(s_wr), .data_e(s_data_e), .phase(s_phase)
  );

  risc_controller #(.HALT_STICKY(1'b0)) dut_ns (
    .clk(clk), .rst(rst), .ena(ena), .opcode(opcode), .zero(zero),
    .sel(n_sel), .rd(n_rd), .ld_ir(n_ld_ir), .halt(n_halt), .inc_pc(n_inc_pc),
    .ld_ac(n_ld_ac), .ld_pc(n_ld_pc), .wr(n_wr), .data_e(n_data_e), .phase(n_phase)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] s;
    logic [11:0] n;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: one sequencer per halt mode.
  int m_ph = 0;
  bit m_halted = 1'b0;
  int n_ph = 0;

  // Expected {phase, sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e} from instruction rules.
  function automatic logic [11:0] model_out(int ph, logic [2:0] op, logic z, bit halted);
    bit fetching, executing, is_alu, is_sto, is_jmp;
    logic [2:0] p;
    logic v_sel, v_rd, v_ld_ir, v_halt, v_inc, v_ld_ac, v_ld_pc, v_wr, v_de;
    fetching  = (ph < 4);
    executing = !fetching;
    is_alu    = executing && (op == 3'd2 || op == 3'd3 || op == 3'd4 || op == 3'd5);
    is_sto    = executing && (op == 3'd6);
    is_jmp    = executing && (op == 3'd7);
    p       = 3'(ph);
    v_sel   = fetching;
    v_rd    = (ph >= 1 && ph <= 3) || (ph >= 5 && is_alu);
    v_ld_ir = (ph == 2 || ph == 3);
    v_halt  = (ph == 4) && (op == 3'd0 || halted);
    v_inc   = (ph == 4) || (ph == 6 && op == 3'd1 && z);
    v_ld_ac = (ph == 7) && is_alu;
    v_ld_pc = (ph >= 6) && is_jmp;
    v_wr    = (ph == 7) && is_sto;
    v_de    = (ph >= 6) && is_sto;
    return {p, v_sel, v_rd, v_ld_ir, v_halt, v_inc, v_ld_ac, v_ld_pc, v_wr, v_de};
  endfunction

  // Drive one cycle of inputs at the falling edge, record expectation, then advance the model.
  task automatic step(input logic r, input logic e, input logic [2:0] op, input logic z);
    exp_t x;
    @(negedge clk);
    rst    = r;
    ena    = e;
    opcode = op;
    zero   = z;
    if (r) begin
      m_ph = 0;
      m_halted = 1'b0;
      n_ph = 0;
    end
    #1;
    x.s = model_out(m_ph, op, z, m_halted);
    x.n = model_out(n_ph, op, z, 1'b0);
    q.push_back(x);
    if (!r) begin
      if (m_halted || (m_ph == 4 && op == 3'd0)) m_halted = 1'b1;
      else if (e) m_ph = (m_ph + 1) % 8;
      if (e) n_ph = (n_ph + 1) % 8;
    end
  endtask

  task automatic instr(input logic [2:0] op, input logic z6, input logic zelse);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, op, (m_ph == 6) ? z6 : zelse);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        x = q.pop_front();
        checks++;
        if ({s_phase, s_sel, s_rd, s_ld_ir, s_halt, s_inc_pc, s_ld_ac, s_ld_pc, s_wr,
             s_data_e} !== x.s) begin
          errors++;
          $display("FAIL sticky t=%0t got=%b exp=%b", $time,
                   {s_phase, s_sel, s_rd, s_ld_ir, s_halt, s_inc_pc, s_ld_ac, s_ld_pc, s_wr,
                    s_data_e}, x.s);
        end
        checks++;
        if ({n_phase, n_sel, n_rd, n_ld_ir, n_halt, n_inc_pc, n_ld_ac, n_ld_pc, n_wr,
             n_data_e} !== x.n) begin
          errors++;
          $display("FAIL nonsticky t=%0t got=%b exp=%b", $time,
                   {n_phase, n_sel, n_rd, n_ld_ir, n_halt, n_inc_pc, n_ld_ac, n_ld_pc, n_wr,
                    n_data_e}, x.n);
        end
      end
    end
  end

  initial begin : stimulus
    logic [2:0] op;
    logic r, e;
    step(1'b1, 1'b0, 3'd0, 1'b0);
    step(1'b1, 1'b1, 3'd2, 1'b0);
    // Directed: ADD, STO, SKZ taken, SKZ not taken with zero toggling elsewhere.
    instr(3'd2, 1'b0, 1'b0);
    instr(3'd6, 1'b0, 1'b0);
    instr(3'd1, 1'b1, 1'b0);
    instr(3'd1, 1'b0, 1'b1);
    // JMP with a three-cycle stall in the ALU phase.
    for (int i = 0; i < 11; i++) begin
      step(1'b0, !(m_ph == 6 && i >= 6 && i < 9), 3'd7, 1'b0);
    end
    while (m_ph != 0) step(1'b0, 1'b1, 3'd2, 1'b0);
    // Reset mid operand fetch.
    while (m_ph != 5) step(1'b0, 1'b1, 3'd6, 1'b0);
    step(1'b1, 1'b1, 3'd6, 1'b0);
    instr(3'd3, 1'b0, 1'b0);
    // HLT: sticky copy freezes at phase 4, the other keeps wrapping.
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 3'd0, 1'b0);
    step(1'b1, 1'b0, 3'd0, 1'b0);
    instr(3'd5, 1'b0, 1'b0);
    // Random traffic; opcode only changes while both sequencers are fetching.
    op = 3'd2;
    for (int i = 0; i < 3000; i++) begin
      if (m_ph < 4 && n_ph < 4 && $urandom_range(1, 0) == 1) op = 3'($urandom_range(7, 0));
      r = ($urandom_range(39, 0) == 0);
      e = ($urandom_range(3, 0) != 0);
      step(r, e, op, 1'($urandom_range(1, 0)));
    end
    @(negedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending exp=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
